// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses, and an optional first-word-fall-through
// read port. Intended for producer/consumer stages sharing one clock.
//
// Handshake: a write is taken when wt_en is high and the FIFO is not full, or
// when it is full but a read pops in the same cycle. A read is taken when rd_en
// is high and the FIFO is not empty; a read against an empty FIFO is refused
// even if a write lands in the same cycle. Refused requests raise overflow or
// underflow for exactly one cycle. All flags and count are registered and
// reflect accepted operations from the previous clock edge.
module sync_fifo_flags #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wt_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the low address bits coincide.
  localparam int CW = PTR_WIDTH + 1;

  localparam logic [PTR_WIDTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PTR_WIDTH:0] ONE_C   = CW'(1);
  localparam logic [PTR_WIDTH:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AE_C    = CW'(AE_LEVEL);

  // Storage (never reset: contents are only meaningful between the pointers)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointer and flag state
  logic [PTR_WIDTH:0] wp_q, wp_d;
  logic [PTR_WIDTH:0] rp_q, rp_d;
  logic [PTR_WIDTH:0] count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               af_q, af_d;
  logic               ae_q, ae_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  // Acceptance decisions
  logic rd_acc;
  logic wr_acc;

  // Acceptance depends only on registered flags plus the current requests,
  // so there is no loop from the requests back into the flags.
  always_comb begin
    rd_acc = rd_en & ~empty_q;
    wr_acc = wt_en & (~full_q | rd_acc);
  end

  // Next-state pointers, occupancy and flags computed from the accepted ops.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (wr_acc) begin
      wp_d = wp_q + ONE_C;
    end
    if (rd_acc) begin
      rp_d = rp_q + ONE_C;
    end
    // Modular subtraction handles pointer wrap naturally.
    count_d = wp_d - rp_d;
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = wt_en & ~wr_acc;
    udf_d   = rd_en & ~rd_acc;
  end

  // Register pointers, flags and error pulses; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Memory write on accepted writes; reset blocks the write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wp_q[PTR_WIDTH-1:0]] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally from memory whenever data is
      // present; a pop moves rp and the next head shows after the edge.
      // While empty the output is forced to zero so it is clean after reset.
      always_comb begin
        rdata = '0;
        if (!empty_q) begin
          rdata = mem_q[rp_q[PTR_WIDTH-1:0]];
        end
      end
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;

      // Registered read: capture the head on an accepted read, hold otherwise.
      // On a full-FIFO read+write the memory write is non-blocking, so the
      // old head is captured even though both pointers address one slot.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rd_acc) begin
          rdata_q <= mem_q[rp_q[PTR_WIDTH-1:0]];
        end
      end

      // Drive the registered read data onto the output.
      always_comb begin
        rdata = rdata_q;
      end
    end
  endgenerate

  // Outputs come straight from registers.
  always_comb begin
    full         = full_q;
    empty        = empty_q;
    almost_full  = af_q;
    almost_empty = ae_q;
    count        = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
// Bench for sync_fifo_flags: one registered-read instance and one FWFT
// instance. A queue-based model tracks the stored words for each and a
// negedge compare process checks every output against it each cycle;
// directed sequences add literal expectations.
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // Registered-read instance signals
  logic          wt_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;

  // FWFT instance signals
  logic          f_wt_en = 1'b0;
  logic          f_rd_en = 1'b0;
  logic [DW-1:0] f_wdata = '0;
  logic [DW-1:0] f_rdata;
  logic          f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0]    f_count;

  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wt_en(wt_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wt_en(f_wt_en), .wdata(f_wdata), .rd_en(f_rd_en), .rdata(f_rdata),
    .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
    .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] f_exp_q[$];
  logic [DW-1:0] m_rdata = '0;
  bit m_ovf = 1'b0, m_udf = 1'b0;
  bit f_ovf = 1'b0, f_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the FIFO rules to the queues using the inputs seen at this edge.
  task automatic model_update();
    bit rok, wok;
    if (rst) begin
      exp_q.delete();
      f_exp_q.delete();
      m_rdata = '0;
      m_ovf = 1'b0; m_udf = 1'b0;
      f_ovf = 1'b0; f_udf = 1'b0;
    end else begin
      rok = rd_en && (exp_q.size() > 0);
      wok = wt_en && ((exp_q.size() < DEPTH) || rok);
      if (rok) m_rdata = exp_q.pop_front();
      if (wok) exp_q.push_back(wdata);
      m_ovf = wt_en && !wok;
      m_udf = rd_en && !rok;

      rok = f_rd_en && (f_exp_q.size() > 0);
      wok = f_wt_en && ((f_exp_q.size() < DEPTH) || rok);
      if (rok) void'(f_exp_q.pop_front());
      if (wok) f_exp_q.push_back(f_wdata);
      f_ovf = f_wt_en && !wok;
      f_udf = f_rd_en && !rok;
    end
  endtask

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", count, exp_q.size());
      chk("full", full, exp_q.size() == DEPTH);
      chk("empty", empty, exp_q.size() == 0);
      chk("almost_full", almost_full, exp_q.size() >= 14);
      chk("almost_empty", almost_empty, exp_q.size() <= 2);
      chk("rdata", rdata, m_rdata);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
      chk("f_count", f_count, f_exp_q.size());
      chk("f_full", f_full, f_exp_q.size() == DEPTH);
      chk("f_empty", f_empty, f_exp_q.size() == 0);
      chk("f_almost_full", f_almost_full, f_exp_q.size() >= 14);
      chk("f_almost_empty", f_almost_empty, f_exp_q.size() <= 2);
      chk("f_overflow", f_overflow, f_ovf);
      chk("f_underflow", f_underflow, f_udf);
      if (f_exp_q.size() > 0) chk("f_rdata", f_rdata, f_exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic op(input bit w, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    rst = 1'b0;
    wt_en = w; wdata = d; rd_en = r;
    f_wt_en = 1'b0; f_wdata = '0; f_rd_en = 1'b0;
    tick();
  endtask

  task automatic fop(input bit w, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    rst = 1'b0;
    wt_en = 1'b0; wdata = '0; rd_en = 1'b0;
    f_wt_en = w; f_wdata = d; f_rd_en = r;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wt_en = 1'b1; wdata = 8'h5A; rd_en = 1'b1;
    f_wt_en = 1'b1; f_wdata = 8'hA5; f_rd_en = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1 Reset with both requests high
    do_reset();
    do_reset();
    chk_en = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_f_empty", f_empty, 1);

    // 2 Fill 0x00..0x0F, one extra write, then drain
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_no_ovf", overflow, 0);
    op(1'b1, 8'hEE, 1'b0);
    chk("extra_ovf", overflow, 1);
    chk("extra_count", count, 16);
    op(1'b0, 8'h00, 1'b0);
    chk("ovf_one_cycle", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 8'h00, 1'b1);
      chk("drain_rdata", rdata, i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // 3 Full plus simultaneous read/write
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0);
    op(1'b1, 8'hAA, 1'b1);
    chk("fullrw_no_ovf", overflow, 0);
    chk("fullrw_count", count, 16);
    chk("fullrw_old_head", rdata, 8'h00);
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] e;
      e = (i < 15) ? 8'(i + 1) : 8'hAA;
      op(1'b0, 8'h00, 1'b1);
      chk("fullrw_drain", rdata, e);
    end
    chk("fullrw_empty", empty, 1);

    // 4 Empty plus simultaneous read/write
    op(1'b1, 8'h55, 1'b1);
    chk("emptyrw_udf", underflow, 1);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_rdata_held", rdata, 8'hAA);
    op(1'b0, 8'h00, 1'b1);
    chk("emptyrw_read", rdata, 8'h55);
    chk("emptyrw_no_udf", underflow, 0);

    // 5 Thresholds walking 0 -> 16 -> 0
    for (int c = 1; c <= 16; c++) begin
      op(1'b1, 8'(c + 8'h30), 1'b0);
      chk("walkup_ae", almost_empty, c <= 2);
      chk("walkup_af", almost_full, c >= 14);
    end
    for (int c = 15; c >= 0; c--) begin
      op(1'b0, 8'h00, 1'b1);
      chk("walkdn_ae", almost_empty, c <= 2);
      chk("walkdn_af", almost_full, c >= 14);
    end

    // 6 FWFT instance
    fop(1'b1, 8'h11, 1'b0);
    chk("fwft_first_visible", f_rdata, 8'h11);
    chk("fwft_not_empty", f_empty, 0);
    fop(1'b1, 8'h22, 1'b0);
    chk("fwft_head_held", f_rdata, 8'h11);
    chk("fwft_count2", f_count, 2);
    fop(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_next", f_rdata, 8'h22);
    chk("fwft_count1", f_count, 1);
    fop(1'b0, 8'h00, 1'b1);
    chk("fwft_drained", f_empty, 1);

    // 7 Random interleaved ops against the scoreboard
    for (int n = 0; n < 40; n++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 99) < 50);
      op(w, 8'($urandom_range(0, 255)), r);
    end

    // Reset mid-operation discards contents and emits no pulses
    op(1'b1, 8'h71, 1'b0);
    op(1'b1, 8'h72, 1'b0);
    do_reset();
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_no_ovf", overflow, 0);
    chk("midrst_no_udf", underflow, 0);
    op(1'b0, 8'h00, 1'b1);
    chk("midrst_read_udf", underflow, 1);
    op(1'b0, 8'h00, 1'b0);
    op(1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
